// File: rtl/proc_multiciclo_param.sv
// Parametrised multicycle processor: shared bus, A/G accumulators, T0..T3 control.
// Define PROC_LOGIC_OPS_EN to enable and/or/slt; otherwise opcodes 101-111 are NOPs.
module proc_multiciclo_param #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic [DATA_W-1:0] DIN,
    input  logic              Run,
    output logic              Done,
    output logic [DATA_W-1:0] BusWires,
    output logic [DATA_W-1:0] Rx_data,
    output logic [DATA_W-1:0] Ry_data
);

    localparam int NREG = 2 ** REG_AW;
    localparam int IR_W = 3 + 2 * REG_AW;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {T0, T1, T2, T3} tstep_t;
    typedef enum logic [2:0] {
        SEL_NONE, SEL_DIN, SEL_RX, SEL_RY, SEL_G
    } bus_sel_t;

    tstep_t state, state_next;
    bus_sel_t bus_sel;

    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] r [NREG];
    logic [DATA_W-1:0] a, g, alu;

    logic [2:0]        opcode;
    logic [REG_AW-1:0] rx, ry;

    logic ir_load, rx_write, a_load, g_load;

    assign opcode = ir[IR_W-1 -: 3];
    assign rx     = ir[2*REG_AW-1 -: REG_AW];
    assign ry     = ir[REG_AW-1:0];

    assign Rx_data = r[rx];
    assign Ry_data = r[ry];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= T0;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bus_sel    = SEL_NONE;
        Done       = 1'b0;
        ir_load    = 1'b0;
        rx_write   = 1'b0;
        a_load     = 1'b0;
        g_load     = 1'b0;
        unique case (state)
            T0: begin
                if (Run) begin
                    ir_load    = 1'b1;
                    state_next = T1;
                end
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        bus_sel    = SEL_RY;
                        rx_write   = 1'b1;
                        Done       = 1'b1;
                        state_next = T0;
                    end
                    OP_MVI: begin
                        bus_sel    = SEL_DIN;
                        rx_write   = 1'b1;
                        Done       = 1'b1;
                        state_next = T0;
                    end
                    OP_MVNZ: begin
                        bus_sel    = SEL_RY;
                        rx_write   = (g != '0);
                        Done       = 1'b1;
                        state_next = T0;
                    end
`ifdef PROC_LOGIC_OPS_EN
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
`else
                    OP_ADD, OP_SUB: begin
`endif
                        bus_sel    = SEL_RX;
                        a_load     = 1'b1;
                        state_next = T2;
                    end
                    default: begin
                        // unimplemented opcode: finish without touching state
                        Done       = 1'b1;
                        state_next = T0;
                    end
                endcase
            end
            T2: begin
                bus_sel    = SEL_RY;
                g_load     = 1'b1;
                state_next = T3;
            end
            T3: begin
                bus_sel    = SEL_G;
                rx_write   = 1'b1;
                Done       = 1'b1;
                state_next = T0;
            end
        endcase
    end

    always_comb begin
        BusWires = '0;
        unique case (bus_sel)
            SEL_DIN:  BusWires = DIN;
            SEL_RX:   BusWires = r[rx];
            SEL_RY:   BusWires = r[ry];
            SEL_G:    BusWires = g;
            default:  BusWires = '0;
        endcase
    end

    always_comb begin
        alu = '0;
        case (opcode)
            OP_ADD: alu = a + BusWires;
            OP_SUB: alu = a - BusWires;
`ifdef PROC_LOGIC_OPS_EN
            OP_AND: alu = a & BusWires;
            OP_OR:  alu = a | BusWires;
            OP_SLT: alu = DATA_W'(a < BusWires);
`endif
            default: alu = '0;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ir <= '0;
            a  <= '0;
            g  <= '0;
            for (int i = 0; i < NREG; i++) begin
                r[i] <= '0;
            end
        end else begin
            if (ir_load) begin
                ir <= DIN[IR_W-1:0];
            end
            if (a_load) begin
                a <= BusWires;
            end
            if (g_load) begin
                g <= alu;
            end
            if (rx_write) begin
                r[rx] <= BusWires;
            end
        end
    end

endmodule

// File: tb/tb_proc_multiciclo_param.sv
// Bench for proc_multiciclo_param: ISA-level model plus per-cycle output compare.
// Follows PROC_LOGIC_OPS_EN the same way the design does.
module tb_proc_multiciclo_param;

    localparam logic [2:0] MV   = 3'b000;
    localparam logic [2:0] MVI  = 3'b001;
    localparam logic [2:0] ADD  = 3'b010;
    localparam logic [2:0] SUB  = 3'b011;
    localparam logic [2:0] MVNZ = 3'b100;
    localparam logic [2:0] ANDO = 3'b101;
    localparam logic [2:0] ORO  = 3'b110;
    localparam logic [2:0] SLT  = 3'b111;

`ifdef PROC_LOGIC_OPS_EN
    localparam bit LOGIC = 1'b1;
`else
    localparam bit LOGIC = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Resetn;
    logic [15:0] DIN;
    logic        Run;
    logic        Done;
    logic [15:0] BusWires, Rx_data, Ry_data;

    proc_multiciclo_param #(.DATA_W(16), .REG_AW(3)) dut (
        .Clock(Clock),
        .Resetn(Resetn),
        .DIN(DIN),
        .Run(Run),
        .Done(Done),
        .BusWires(BusWires),
        .Rx_data(Rx_data),
        .Ry_data(Ry_data)
    );

    always #5 Clock = ~Clock;

    logic [15:0] m_r [8];
    logic [15:0] m_a, m_g;
    int          cur_rx, cur_ry;
    logic        exp_done;
    logic [15:0] exp_bus;
    bit          chk_en;
    int          checks, errors;

    function automatic logic [15:0] alu_model(input logic [2:0] op,
                                              input logic [15:0] x,
                                              input logic [15:0] y);
        case (op)
            ADD:     return x + y;
            SUB:     return x - y;
            ANDO:    return x & y;
            ORO:     return x | y;
            SLT:     return (x < y) ? 16'd1 : 16'd0;
            default: return 16'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (chk_en) begin
            chk("done", 16'(Done), 16'(exp_done));
            chk("bus", BusWires, exp_bus);
            chk("rx_data", Rx_data, m_r[cur_rx]);
            chk("ry_data", Ry_data, m_r[cur_ry]);
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        m_a = '0;
        m_g = '0;
        cur_rx = 0;
        cur_ry = 0;
        exp_done = 1'b0;
        exp_bus = '0;
    endtask

    task automatic idle(input int n);
        Run = 1'b0;
        DIN = {7'd0, MVI, 3'd0, 3'd0};
        exp_done = 1'b0;
        exp_bus = '0;
        repeat (n) step();
    endtask

    // Run stays high through T1..T3 so the next call fetches back-to-back.
    task automatic do_instr(input logic [2:0] op, input int rx, input int ry,
                            input logic [15:0] imm);
        logic [15:0] b;
        DIN = {7'd0, op, 3'(rx), 3'(ry)};
        Run = 1'b1;
        exp_done = 1'b0;
        exp_bus = '0;
        step();
        cur_rx = rx;
        cur_ry = ry;
        DIN = (op == MVI) ? imm : 16'hDEAD;
        if (op == MV || op == MVI || op == MVNZ) begin
            b = (op == MVI) ? imm : m_r[ry];
            exp_bus = b;
            exp_done = 1'b1;
            step();
            if (op != MVNZ || m_g != 0) m_r[rx] = b;
        end else if (op >= ANDO && !LOGIC) begin
            exp_bus = '0;
            exp_done = 1'b1;
            step();
        end else begin
            exp_bus = m_r[rx];
            step();
            m_a = m_r[rx];
            exp_bus = m_r[ry];
            step();
            m_g = alu_model(op, m_a, m_r[ry]);
            exp_bus = m_g;
            exp_done = 1'b1;
            step();
            m_r[rx] = m_g;
        end
        exp_done = 1'b0;
        exp_bus = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        Resetn = 1'b0;
        Run = 1'b0;
        DIN = '0;
        model_reset();
        repeat (2) step();
        chk("reset_done", 16'(Done), 16'd0);
        chk("reset_bus", BusWires, 16'd0);
        chk("reset_rx", Rx_data, 16'd0);
        Resetn = 1'b1;
        chk_en = 1'b1;

        idle(5);

        do_instr(MVI, 0, 0, 16'd11);
        do_instr(MVI, 1, 0, 16'd10);
        do_instr(MV, 0, 1, 16'd0);
        chk("lit_mv_r0", Rx_data, 16'd10);
        chk("lit_mv_r1", Ry_data, 16'd10);

        do_instr(MVI, 0, 0, 16'd11);
        do_instr(MVNZ, 0, 1, 16'd0);
        chk("lit_mvnz_g0", Rx_data, 16'd11);

        do_instr(MVI, 0, 0, 16'd5);
        do_instr(SUB, 1, 0, 16'd0);
        chk("lit_sub", Rx_data, 16'd5);

        do_instr(MVI, 1, 0, 16'd10);
        do_instr(MVI, 0, 0, 16'd11);
        do_instr(MVNZ, 0, 1, 16'd0);
        chk("lit_mvnz_g5", Rx_data, 16'd10);

        do_instr(MVI, 2, 0, 16'hFFFF);
        do_instr(MVI, 3, 0, 16'd2);
        do_instr(ADD, 2, 3, 16'd0);
        chk("lit_add_wrap", Rx_data, 16'h0001);

        do_instr(MVI, 4, 0, 16'h1234);
        do_instr(SUB, 4, 4, 16'd0);
        chk("lit_sub_self", Rx_data, 16'h0000);

        do_instr(MVI, 1, 0, 16'd3);
        do_instr(MVI, 0, 0, 16'd7);
        do_instr(SLT, 1, 0, 16'd0);
        chk("lit_slt", Rx_data, LOGIC ? 16'd1 : 16'd3);

        do_instr(MVI, 5, 0, 16'hF0F0);
        do_instr(MVI, 6, 0, 16'hFF00);
        do_instr(ANDO, 5, 6, 16'd0);
        chk("lit_and", Rx_data, LOGIC ? 16'hF000 : 16'hF0F0);
        do_instr(ORO, 6, 5, 16'd0);
        chk("lit_or", Rx_data, LOGIC ? (LOGIC ? 16'hF000 | 16'hFF00 : 16'h0) : 16'hFF00);
        do_instr(SLT, 0, 1, 16'd0);
        do_instr(ADD, 3, 3, 16'd0);
        chk("lit_add_self", Rx_data, 16'd4);

        idle(3);

        // abort an add in T2 with an asynchronous reset
        do_instr(MVI, 2, 0, 16'd3);
        do_instr(MVI, 3, 0, 16'd4);
        DIN = {7'd0, ADD, 3'd2, 3'd3};
        Run = 1'b1;
        step();
        cur_rx = 2;
        cur_ry = 3;
        exp_bus = m_r[2];
        step();
        exp_bus = m_r[3];
        Resetn = 1'b0;
        model_reset();
        #1;
        chk("abort_done", 16'(Done), 16'd0);
        chk("abort_bus", BusWires, 16'd0);
        chk("abort_rx", Rx_data, 16'd0);
        chk("abort_ry", Ry_data, 16'd0);
        repeat (2) step();
        Resetn = 1'b1;
        idle(2);
        do_instr(MV, 5, 2, 16'd0);
        chk("lit_after_abort", Ry_data, 16'd0);
        do_instr(MVI, 2, 0, 16'd9);
        do_instr(ADD, 2, 2, 16'd0);
        chk("lit_resume_add", Rx_data, 16'd18);
        idle(2);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/proc_multiciclo_param.md
# proc_multiciclo_param

Parametrised multicycle processor core: generalises the fixed 16-bit, 8-register multicycle processor to configurable data width and register-file size, and adds logic/compare instructions. It executes one instruction at a time over a shared bus (BusWires) with an A/G accumulator pair and a step counter (Tstep), fetching instructions and immediates from DIN under a Run/Done handshake. It is the top-level datapath plus control used by the processor testbenches.

## Interface
- DATA_W, 16: width of DIN, registers R0..R(NREG-1), A, G and BusWires; must be ≥ IR_W.
- REG_AW, 3: register-index width; NREG = 2**REG_AW; IR_W = 3 + 2*REG_AW.
- Clock  in  1  single clock; all state updates on rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- DIN  in  DATA_W  instruction in DIN[IR_W-1:0] during T0; immediate during mvi T1.
- Run  in  1  start request, sampled only in T0.
- Done  out  1  high (combinational) during the final step of an instruction.
- BusWires  out  DATA_W  shared bus value.
- Rx_data  out  DATA_W  debug: current contents of register selected by IR Rx field.
- Ry_data  out  DATA_W  debug: current contents of register selected by IR Ry field.

## Operation
- IR fields: opcode = IR[IR_W-1:IR_W-3], Rx = IR[2*REG_AW-1:REG_AW], Ry = IR[REG_AW-1:0].
- Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 mvnz, 101 and, 110 or, 111 slt.
- Tstep: 2-bit state T0..T3; returns to T0 on the edge after Done is high.
- T0 (fetch): if Run=1, IR <= DIN[IR_W-1:0], go T1; else stay T0, no state change. BusWires = 0.
- mv T1: bus = R[Ry]; R[Rx] <= bus; Done.
- mvi T1: bus = DIN; R[Rx] <= bus; Done.
- mvnz T1: bus = R[Ry]; R[Rx] <= bus only if G != 0; Done regardless.
- ALU ops: T1 bus = R[Rx], A <= bus; T2 bus = R[Ry], G <= A op bus; T3 bus = G, R[Rx] <= bus, Done.
- add/sub: modulo 2**DATA_W, no flags. sub is A - bus. and/or bitwise. slt: G = (A < bus, unsigned) ? 1 : 0.
- Bus mux: exactly one source per step; no source selected -> 0.
- Rx = Ry is legal (e.g. sub R2,R2 -> R2 = 0).

## Timing
- Reset (asynchronous, Resetn=0): all R, A, G, IR = 0; Tstep = T0; Done = 0; BusWires = 0; Rx_data = Ry_data = 0.
- Reset mid-instruction aborts immediately; no partial write completes; resumes in T0 after release.
- Latency from Run sampled high in T0: mv/mvi/mvnz Done in cycle 2 (T1); ALU ops Done in cycle 4 (T3).
- Run ignored in T1..T3; new fetch only in T0 following Done. Back-to-back: Run held high gives no idle cycle.
- Register/A/G writes occur at the rising edge ending the step; Done deasserts in the T0 after that edge.
- mvi immediate must be valid on DIN during T1 (one cycle after the instruction word).

## Configuration
- PROC_LOGIC_OPS_EN defined: opcodes 101 (and), 110 (or), 111 (slt) execute as above.
- Not defined: opcodes 101-111 are NOPs: T1 asserts Done, bus = 0, no register/A/G write; ALU contains only add/sub.

## Test plan
- Reset: hold Resetn=0 mid ALU instruction (T2) -> all outputs/registers 0, Tstep=T0 immediately, no write to Rx.
- mv R0,R1 with R0=11, R1=10, Run=1 -> Done in T1, BusWires=10, R0=10 after edge, R1 unchanged.
- mvi R0 then DIN=5 -> R0=5 after T1; then sub R1,R0 with R1=10 -> A=10 after T1, G=5 after T2, R1=5 with Done in T3.
- mvnz R0,R1 (R0=11, R1=10): G=0 -> R0 stays 11, Done in T1; G=5 -> R0=10.
- DATA_W=16: add R2,R3 with R2=0xFFFF, R3=2 -> R2=0x0001 (wrap); sub R4,R4 -> R4=0.
- PROC_LOGIC_OPS_EN defined: slt R1,R0 with R1=3, R0=7 -> R1=1; and 0xF0F0 & 0xFF00 -> 0xF000. Undefined: opcode 101 -> Done in T1, no register changes. Run=0 in T0 for 5 cycles -> Tstep stays T0, Done=0.
